mealy_ctx_arbiter: RTL and testbench
====================================

// Module: mealy_ctx_arbiter
// PURPOSE
//   Shares one 4-state Mealy engine (states s0..s3, input A, output Z) among N requesters.
//   Each requester owns a saved 2-bit state context. A round-robin arbiter grants one
//   requester per cycle, and that requester's A bit advances its own context.
//   Sits between the per-channel bit sources and the downstream Z consumers.
// PARAMETERS
//   N     4   number of requesters (2..16)
//   CNTW  8   width of the saturating global Z-hit counter
// PORTS
//   clk         in   1           rising-edge clock
//   rst         in   1           asynchronous reset, active-high
//   en          in   1           arbitration enable; low = no grants
//   req         in   N           per-requester request, level; one A bit consumed per grant
//   a           in   N           per-requester A bit, valid while req[i]=1
//   clr         in   N           synchronous per-requester context clear to s0
//   gnt         out  N           one-hot grant, combinational, same cycle as req
//   resp_valid  out  1           registered; one grant was processed in the previous cycle
//   resp_id     out  clog2(N)    index of the requester processed
//   resp_z      out  1           Mealy Z for that step
//   resp_state  out  2           new context state of resp_id
//   ctx_state   out  2*N         all contexts; [2i+1:2i] = requester i
//   z_cnt       out  CNTW        saturating count of steps with Z=1
// BEHAVIOUR
//   Reset (async, rst=1):
//     - All contexts = s0; RR pointer = 0.
//     - resp_valid/resp_id/resp_z/resp_state/z_cnt = 0; gnt = 0 while rst=1.
//   Transition table (state, A -> next, Z):
//     - s0: 0->s0 Z0,  1->s3 Z1
//     - s1: 0->s1 Z0,  1->s0 Z1
//     - s2: 0->s2 Z0,  1->s1 Z0
//     - s3: 0->s2 Z0,  1->s1 Z0
//     - State encoding: s0=0, s1=1, s2=2, s3=3.
//   Arbitration (combinational, each cycle):
//     - Eligible set: req[i] & ~clr[i] & en.
//     - Search starts at the RR pointer, ascending with wrap. The first eligible i gets gnt[i]=1.
//     - gnt has at most one bit set. If nothing is eligible, gnt=0.
//   Clock edge ending a cycle with gnt[g]=1:
//     - ctx[g] <= next(ctx[g], a[g]).
//     - resp_valid<=1, resp_id<=g, resp_z<=Z, resp_state<=next.
//     - RR pointer <= (g+1) mod N.
//     - If Z=1 and z_cnt != all-ones: z_cnt += 1. At all-ones, z_cnt holds.
//   Clock edge ending a cycle with no grant:
//     - resp_valid<=0. resp_id/resp_z/resp_state hold. Pointer holds.
//   Latency: response is visible 1 cycle after the grant cycle.
//     - Back-to-back grants give resp_valid=1 every cycle.
//   Same requester granted on consecutive cycles (sole requester):
//     - Second step uses the context already updated by the first. No hazard, no bubble.
//   clr[i]=1:
//     - ctx[i] <= s0 at the edge. Requester i is masked from that cycle's arbitration.
//     - Its req is not consumed. Other requesters are unaffected. clr on several bits clears all of them.
//   en=0: no grants and no context advance. clr is still honoured. Pointer holds.
//   ctx_state is a direct register view. It reflects an update in the cycle after the edge.
//   Async reset mid-stream:
//     - Any in-flight step is discarded. Contexts return to s0 immediately.
//     - The first grant after release goes to the lowest-index eligible requester.
// TESTING
//   1. Reset, N=4, req=0001, a[0] sequence 1,1,0,1.
//      -> resp_state 3,1,1,0; resp_z 1,0,0,1; z_cnt=2.
//   2. req=1111 held 8 cycles, en=1.
//      -> gnt 0001,0010,0100,1000,0001,...; resp_id 0,1,2,3,0,... one cycle later.
//   3. req=1010 with pointer=0.
//      -> gnt=0010, then 1000, then 0010. Requesters 0 and 2 are never granted.
//   4. ctx0=s3 and req[0]=1 with clr[0]=1 in the same cycle.
//      -> gnt[0]=0, ctx0=s0 next cycle. Next cycle with a=1 gives resp_z=1, resp_state=3.
//   5. CNTW=2, single requester, A alternating 1,1 from s0 (Z=1 every s0/s1 step) for 6 Z hits.
//      -> z_cnt stops at 3.
//   6. Assert rst mid-stream with req=1111 at pointer=2.
//      -> ctx_state=0, resp_valid=0 immediately. After release, first gnt=0001.

Source files
------------

// File: rtl/mealy_ctx_arbiter.sv
// rtl/mealy_ctx_arbiter.sv - one shared 4-state Mealy engine time-multiplexed over N round-robin requesters
module mealy_ctx_arbiter #(
    parameter int N    = 4,
    parameter int CNTW = 8,
    localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N-1:0]      req,
    input  logic [N-1:0]      a,
    input  logic [N-1:0]      clr,
    output logic [N-1:0]      gnt,
    output logic              resp_valid,
    output logic [IDW-1:0]    resp_id,
    output logic              resp_z,
    output logic [1:0]        resp_state,
    output logic [2*N-1:0]    ctx_state,
    output logic [CNTW-1:0]   z_cnt
);

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_t;

    logic [2*N-1:0] ctx;
    logic [2*N-1:0] ctx_next;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_next;
    logic [IDW-1:0] gidx;
    logic [IDW-1:0] idx;
    logic [IDW:0]   sum;
    logic [N-1:0]   elig;
    logic           gfound;
    logic           a_g;
    state_t         cur_st;
    state_t         nxt_st;
    logic           step_z;

    // Gating with rst keeps gnt low for the whole reset window, not just at edges.
    assign elig = req & ~clr & {N{en & ~rst}};

    always_comb begin
        gnt    = '0;
        gidx   = '0;
        gfound = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(N)) begin
                sum = sum - (IDW+1)'(N);
            end
            idx = sum[IDW-1:0];
            if (!gfound && elig[idx]) begin
                gfound   = 1'b1;
                gidx     = idx;
                gnt[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        a_g    = a[gidx];
        cur_st = state_t'(ctx[{gidx, 1'b0} +: 2]);
        nxt_st = cur_st;
        step_z = 1'b0;
        case (cur_st)
            S0: begin
                nxt_st = a_g ? S3 : S0;
                step_z = a_g;
            end
            S1: begin
                nxt_st = a_g ? S0 : S1;
                step_z = a_g;
            end
            S2:      nxt_st = a_g ? S1 : S2;
            S3:      nxt_st = a_g ? S1 : S2;
            default: nxt_st = S0;
        endcase
    end

    // A cleared requester is never granted, so clear and advance cannot collide.
    always_comb begin
        ctx_next = ctx;
        for (int i = 0; i < N; i++) begin
            if (clr[i]) begin
                ctx_next[2*i +: 2] = S0;
            end else if (gnt[i]) begin
                ctx_next[2*i +: 2] = nxt_st;
            end
        end
    end

    always_comb begin
        ptr_next = ptr;
        if (gfound) begin
            ptr_next = (gidx == IDW'(N-1)) ? '0 : gidx + IDW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctx        <= '0;
            ptr        <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_z     <= 1'b0;
            resp_state <= 2'd0;
            z_cnt      <= '0;
        end else begin
            ctx        <= ctx_next;
            ptr        <= ptr_next;
            resp_valid <= gfound;
            if (gfound) begin
                resp_id    <= gidx;
                resp_z     <= step_z;
                resp_state <= nxt_st;
                if (step_z && (z_cnt != {CNTW{1'b1}})) begin
                    z_cnt <= z_cnt + CNTW'(1);
                end
            end
        end
    end

    assign ctx_state = ctx;

endmodule

// File: tb/tb_mealy_ctx_arbiter.sv
// tb/tb_mealy_ctx_arbiter.sv - table-driven directed bench for mealy_ctx_arbiter
module tb_mealy_ctx_arbiter;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] req, a, clr, gnt;
    logic       resp_valid, resp_z;
    logic [1:0] resp_id, resp_state;
    logic [7:0] ctx_state, z_cnt;

    logic       s_en;
    logic [1:0] s_req, s_a, s_clr, s_gnt;
    logic       s_rv, s_z;
    logic [0:0] s_id;
    logic [1:0] s_st;
    logic [3:0] s_ctx;
    logic [1:0] s_zc;

    int total  = 0;
    int passed = 0;

    mealy_ctx_arbiter #(.N(4), .CNTW(8)) u_dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .a(a), .clr(clr), .gnt(gnt),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_z(resp_z),
        .resp_state(resp_state), .ctx_state(ctx_state), .z_cnt(z_cnt)
    );

    mealy_ctx_arbiter #(.N(2), .CNTW(2)) u_sat (
        .clk(clk), .rst(rst), .en(s_en), .req(s_req), .a(s_a), .clr(s_clr), .gnt(s_gnt),
        .resp_valid(s_rv), .resp_id(s_id), .resp_z(s_z),
        .resp_state(s_st), .ctx_state(s_ctx), .z_cnt(s_zc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [3:0] req;
        logic [3:0] a;
        logic [3:0] clr;
        logic [3:0] gnt;
        logic       rv;
        logic [1:0] id;
        logic       z;
        logic [1:0] st;
        logic [7:0] ctx;
        logic [7:0] zc;
    } vec_t;

    vec_t tbl[22];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic e, input logic [3:0] rq, input logic [3:0] av,
                                input logic [3:0] cl, input logic [3:0] g, input logic rv,
                                input logic [1:0] id, input logic z, input logic [1:0] st,
                                input logic [7:0] cx, input logic [7:0] zc);
        vec_t v;
        v.en = e; v.req = rq; v.a = av; v.clr = cl; v.gnt = g; v.rv = rv;
        v.id = id; v.z = z; v.st = st; v.ctx = cx; v.zc = zc;
        return v;
    endfunction

    initial begin
        // Single requester walk: 1,1,0,1 from s0
        tbl[0]  = mk(1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, 0, 1, 3, 8'h03, 8'd1);
        tbl[1]  = mk(1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, 0, 0, 1, 8'h01, 8'd1);
        tbl[2]  = mk(1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 0, 0, 1, 8'h01, 8'd1);
        tbl[3]  = mk(1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, 0, 1, 0, 8'h00, 8'd2);
        // All four requesting, pointer sits at 1
        tbl[4]  = mk(1, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 1, 1, 0, 0, 8'h00, 8'd2);
        tbl[5]  = mk(1, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 1, 2, 0, 0, 8'h00, 8'd2);
        tbl[6]  = mk(1, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 1, 3, 0, 0, 8'h00, 8'd2);
        tbl[7]  = mk(1, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 1, 0, 0, 0, 8'h00, 8'd2);
        tbl[8]  = mk(1, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 1, 1, 0, 0, 8'h00, 8'd2);
        tbl[9]  = mk(1, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 1, 2, 0, 0, 8'h00, 8'd2);
        tbl[10] = mk(1, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 1, 3, 0, 0, 8'h00, 8'd2);
        tbl[11] = mk(1, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 1, 0, 0, 0, 8'h00, 8'd2);
        tbl[12] = mk(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 8'h00, 8'd2);
        // Sparse requests 1010
        tbl[13] = mk(1, 4'b1010, 4'b1010, 4'b0000, 4'b0010, 1, 1, 1, 3, 8'h0C, 8'd3);
        tbl[14] = mk(1, 4'b1010, 4'b1010, 4'b0000, 4'b1000, 1, 3, 1, 3, 8'hCC, 8'd4);
        tbl[15] = mk(1, 4'b1010, 4'b0000, 4'b0000, 4'b0010, 1, 1, 0, 2, 8'hC8, 8'd4);
        // en low still clears; clr masks a requester from arbitration
        tbl[16] = mk(0, 4'b1111, 4'b1111, 4'b1000, 4'b0000, 0, 1, 0, 2, 8'h08, 8'd4);
        tbl[17] = mk(1, 4'b1111, 4'b0000, 4'b0100, 4'b1000, 1, 3, 0, 0, 8'h08, 8'd4);
        // ctx0 at s3, clr with req in same cycle, then step from s0
        tbl[18] = mk(1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, 0, 1, 3, 8'h0B, 8'd5);
        tbl[19] = mk(1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 0, 0, 1, 3, 8'h08, 8'd5);
        tbl[20] = mk(1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, 0, 1, 3, 8'h0B, 8'd6);
        tbl[21] = mk(1, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 0, 1, 3, 8'h00, 8'd6);

        rst = 1'b1; en = 1'b1; req = 4'b1111; a = 4'b1111; clr = 4'b0000;
        s_en = 1'b1; s_req = 2'b00; s_a = 2'b00; s_clr = 2'b00;
        #3;
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_resp", 32'({resp_valid, resp_id, resp_z, resp_state}), 32'h0);
        chk("reset_ctx", 32'(ctx_state), 32'h0);
        chk("reset_zcnt", 32'({z_cnt, s_zc}), 32'h0);
        req = 4'b0000; a = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 22; i++) begin
            en = tbl[i].en; req = tbl[i].req; a = tbl[i].a; clr = tbl[i].clr;
            #1;
            chk($sformatf("gnt[%0d]", i), 32'(gnt), 32'(tbl[i].gnt));
            @(posedge clk); #1;
            chk($sformatf("resp[%0d]", i),
                32'({resp_valid, resp_id, resp_z, resp_state, ctx_state, z_cnt}),
                32'({tbl[i].rv, tbl[i].id, tbl[i].z, tbl[i].st, tbl[i].ctx, tbl[i].zc}));
        end
        en = 1'b1; req = 4'b0000; a = 4'b0000; clr = 4'b0000;

        // Saturating counter on 2-bit instance, a=1 constantly: Z = 1,0,1,1,0,1,...
        s_req = 2'b01; s_a = 2'b01;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (k == 1) chk("sat_step1", 32'({s_rv, s_z, s_st, s_zc}), 32'({1'b1, 1'b1, 2'd3, 2'd1}));
            if (k == 3) chk("sat_step3", 32'({s_z, s_st, s_zc}), 32'({1'b1, 2'd0, 2'd2}));
            if (k == 4) chk("sat_step4", 32'(s_zc), 32'd3);
        end
        chk("sat_hold", 32'(s_zc), 32'd3);
        s_req = 2'b00; s_a = 2'b00;

        // Async reset mid-stream with pointer at 2
        req = 4'b1111; a = 4'b1111;
        #1;
        chk("pre_rst_gnt", 32'(gnt), 32'b0010);
        @(posedge clk); #1;
        chk("pre_rst_ctx", 32'(ctx_state), 32'h0C);
        chk("ptr2_gnt", 32'(gnt), 32'b0100);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_ctx", 32'(ctx_state), 32'h0);
        chk("mid_rst_valid", 32'({resp_valid, gnt}), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_gnt", 32'(gnt), 32'b0001);
        @(posedge clk); #1;
        chk("post_rst_resp", 32'({resp_valid, resp_id, resp_state}), 32'({1'b1, 2'd0, 2'd3}));
        req = 4'b0000; a = 4'b0000;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
